// File: rtl/clken_gen.sv
// Multi-channel fractional clock-enable generator: per-channel phase accumulators
// whose carries become one-cycle enable strobes, gated until PLL lock has settled.
module clken_gen #(
   parameter int unsigned NUM_CLOCKS  = 2,
   parameter int unsigned ACC_W       = 32,
   parameter int unsigned LOCK_CYCLES = 1024,
   parameter logic [ACC_W-1:0] INIT_INC = '0,
   localparam int unsigned CH_W = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
   input  logic                  refclk,
   input  logic                  rst,
   input  logic                  pll_locked,
   input  logic                  sync,
   input  logic                  cfg_wr,
   input  logic [CH_W-1:0]       cfg_ch,
   input  logic                  cfg_sel,
   input  logic [ACC_W-1:0]      cfg_data,
   output logic [NUM_CLOCKS-1:0] ce,
   output logic                  locked
);

   localparam int unsigned CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      SETTLE    = 2'd1,
      RUN       = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             lk_meta, lk_s;

   logic [ACC_W-1:0] inc_q   [NUM_CLOCKS];
   logic [ACC_W-1:0] phase_q [NUM_CLOCKS];
   logic [ACC_W-1:0] acc_q   [NUM_CLOCKS];
   logic [ACC_W-1:0] inc_nxt   [NUM_CLOCKS];
   logic [ACC_W-1:0] phase_nxt [NUM_CLOCKS];
   logic [ACC_W-1:0] acc_nxt   [NUM_CLOCKS];
   logic [ACC_W:0]   sum       [NUM_CLOCKS];
   logic [NUM_CLOCKS-1:0] ce_nxt;
   logic             wr_ok;
   logic             do_add;

   // State register, settle counter and lock synchroniser
   always_ff @(posedge refclk) begin
      if (rst) begin
         state   <= WAIT_LOCK;
         cnt     <= '0;
         lk_meta <= 1'b0;
         lk_s    <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         lk_meta <= pll_locked;
         lk_s    <= lk_meta;
      end
   end

   // Lock sequencing: any loss of synchronised lock returns to WAIT_LOCK
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         WAIT_LOCK: begin
            if (lk_s) begin
               state_nxt = SETTLE;
               cnt_nxt   = '0;
            end
         end
         SETTLE: begin
            if (!lk_s) begin
               state_nxt = WAIT_LOCK;
            end else if (cnt == CNT_LAST) begin
               state_nxt = RUN;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         RUN: begin
            if (!lk_s) begin
               state_nxt = WAIT_LOCK;
            end
         end
         default: state_nxt = WAIT_LOCK;
      endcase
   end

   assign wr_ok  = cfg_wr && (32'(cfg_ch) < NUM_CLOCKS);
   assign do_add = (state == RUN) && lk_s && !sync;

   // Config update and accumulator step; a reload always sees this cycle's phase write
   always_comb begin
      ce_nxt = '0;
      for (int c = 0; c < int'(NUM_CLOCKS); c++) begin
         inc_nxt[c]   = inc_q[c];
         phase_nxt[c] = phase_q[c];
         if (wr_ok && (cfg_ch == CH_W'(c))) begin
            if (cfg_sel) begin
               phase_nxt[c] = cfg_data;
            end else begin
               inc_nxt[c] = cfg_data;
            end
         end
         sum[c] = {1'b0, acc_q[c]} + {1'b0, inc_q[c]};
         if (do_add) begin
            acc_nxt[c] = sum[c][ACC_W-1:0];
            ce_nxt[c]  = sum[c][ACC_W];
         end else begin
            acc_nxt[c] = phase_nxt[c];
         end
      end
   end

   always_ff @(posedge refclk) begin
      if (rst) begin
         ce     <= '0;
         locked <= 1'b0;
         for (int c = 0; c < int'(NUM_CLOCKS); c++) begin
            inc_q[c]   <= INIT_INC;
            phase_q[c] <= '0;
            acc_q[c]   <= '0;
         end
      end else begin
         ce     <= ce_nxt;
         locked <= (state_nxt == RUN);
         for (int c = 0; c < int'(NUM_CLOCKS); c++) begin
            inc_q[c]   <= inc_nxt[c];
            phase_q[c] <= phase_nxt[c];
            acc_q[c]   <= acc_nxt[c];
         end
      end
   end

endmodule

// File: tb/tb_clken_gen.sv
// Bench for clken_gen: directed scenarios plus random traffic, compared every
// cycle against an arithmetic model of strobe rate, lock streak and reloads.
module tb_clken_gen;

   localparam int unsigned NC = 3;
   localparam int unsigned AW = 32;
   localparam int unsigned LC = 16;
   localparam logic [AW-1:0] II = 32'h8000_0000;
   localparam longint unsigned MASK = (64'd1 << AW) - 64'd1;

   logic          refclk = 1'b0;
   logic          rst = 1'b1;
   logic          pll_locked = 1'b0;
   logic          sync = 1'b0;
   logic          cfg_wr = 1'b0;
   logic [1:0]    cfg_ch = '0;
   logic          cfg_sel = 1'b0;
   logic [AW-1:0] cfg_data = '0;
   logic [NC-1:0] ce;
   logic          locked;

   int n_chk = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   clken_gen #(
      .NUM_CLOCKS (NC),
      .ACC_W      (AW),
      .LOCK_CYCLES(LC),
      .INIT_INC   (II)
   ) dut (
      .refclk    (refclk),
      .rst       (rst),
      .pll_locked(pll_locked),
      .sync      (sync),
      .cfg_wr    (cfg_wr),
      .cfg_ch    (cfg_ch),
      .cfg_sel   (cfg_sel),
      .cfg_data  (cfg_data),
      .ce        (ce),
      .locked    (locked)
   );

   always #5 refclk = ~refclk;

   // Reference model: strobes are carries out of acc+inc; outputs are released
   // once synchronised lock has been seen on LC+1 consecutive edges.
   longint unsigned m_inc [NC];
   longint unsigned m_old [NC];
   longint unsigned m_phase [NC];
   longint unsigned m_acc [NC];
   longint unsigned m_sum;
   logic [NC-1:0]   m_ce = '0;
   bit              m_locked = 1'b0;
   bit              m_s1, m_s2, m_lk;
   int              m_streak = 0;

   always @(posedge refclk) begin
      if (rst) begin
         m_s1 = 1'b0;
         m_s2 = 1'b0;
         m_streak = 0;
         m_locked = 1'b0;
         m_ce = '0;
         for (int c = 0; c < NC; c++) begin
            m_inc[c] = II;
            m_phase[c] = 0;
            m_acc[c] = 0;
         end
      end else begin
         m_lk = m_s2;
         m_s2 = m_s1;
         m_s1 = pll_locked;
         for (int c = 0; c < NC; c++) m_old[c] = m_inc[c];
         if (cfg_wr && (int'(cfg_ch) < NC)) begin
            if (cfg_sel) m_phase[cfg_ch] = cfg_data;
            else         m_inc[cfg_ch] = cfg_data;
         end
         for (int c = 0; c < NC; c++) begin
            if (m_locked && m_lk && !sync) begin
               m_sum = m_acc[c] + m_old[c];
               m_ce[c] = 1'((m_sum >> AW) & 64'd1);
               m_acc[c] = m_sum & MASK;
            end else begin
               m_ce[c] = 1'b0;
               m_acc[c] = m_phase[c];
            end
         end
         m_streak = m_lk ? m_streak + 1 : 0;
         if (m_streak > int'(LC) + 1) m_streak = int'(LC) + 1;
         m_locked = (m_streak >= int'(LC) + 1);
      end
   end

   always @(posedge refclk) begin
      #1;
      if (chk_en) begin
         n_chk++;
         if (ce !== m_ce || locked !== m_locked) begin
            n_fail++;
            $display("FAIL model_cycle t=%0t ce=%b locked=%b required ce=%b locked=%b",
                     $time, ce, locked, m_ce, m_locked);
         end
      end
   end

   task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s t=%0t got=%0h required=%0h", name, $time, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge refclk);
   endtask

   task automatic cfg(input logic [1:0] ch, input logic sel, input logic [AW-1:0] d);
      cfg_wr = 1'b1;
      cfg_ch = ch;
      cfg_sel = sel;
      cfg_data = d;
      @(negedge refclk);
      cfg_wr = 1'b0;
   endtask

   task automatic pulse_sync();
      sync = 1'b1;
      @(negedge refclk);
      sync = 1'b0;
   endtask

   // Edges from the first one sampling pll_locked high until locked is seen
   task automatic wait_locked(input string name);
      int lat;
      bit ce_seen;
      lat = 0;
      ce_seen = 1'b0;
      do begin
         @(negedge refclk);
         lat++;
         if (!locked && ce != '0) ce_seen = 1'b1;
      end while (!locked && lat < 200);
      check({name, "_lock_latency"}, longint'(lat - 1), longint'(LC + 2));
      check({name, "_ce_gated"}, longint'(ce_seen), 0);
   endtask

   int cnt0, cnt1, cntx;

   initial begin
      step(3);
      chk_en = 1'b1;
      check("reset_ce", longint'(ce), 0);
      check("reset_locked", longint'(locked), 0);
      rst = 1'b0;
      step(2);

      // Lock sequencing
      pll_locked = 1'b1;
      wait_locked("first");
      for (int k = 0; k < 4; k++) begin
         step(1);
         check("init_toggle", longint'(ce), (k % 2 == 1) ? 64'h7 : 64'h0);
      end

      // Fractional rate
      cfg(2'd0, 1'b0, 32'h5555_5556);
      cfg(2'd1, 1'b0, 32'h4000_0000);
      cfg(2'd2, 1'b0, 32'h0);
      pulse_sync();
      cnt0 = 0;
      cnt1 = 0;
      for (int k = 0; k < 300; k++) begin
         step(1);
         cnt0 += int'(ce[0]);
         cnt1 += int'(ce[1]);
      end
      check("rate_ch0", longint'(cnt0), 100);
      check("rate_ch1", longint'(cnt1), 75);

      // Phase offset and sync
      cfg(2'd1, 1'b1, 32'hC000_0000);
      pulse_sync();
      check("sync_quiet", longint'(ce[1]), 0);
      step(1);
      check("sync_first", longint'(ce[1]), 1);
      for (int k = 1; k <= 8; k++) begin
         step(1);
         check("sync_period", longint'(ce[1]), (k % 4 == 0) ? 64'd1 : 64'd0);
      end

      // Lock loss mid-run
      pll_locked = 1'b0;
      step(3);
      check("drop_locked", longint'(locked), 0);
      check("drop_ce", longint'(ce), 0);
      pll_locked = 1'b1;
      wait_locked("relock");
      step(1);
      check("relock_phase", longint'(ce), 64'h2);

      // inc = 0 is silent
      cfg(2'd0, 1'b0, 32'h0);
      cfg(2'd1, 1'b0, 32'h0);
      cntx = 0;
      for (int k = 0; k < 1000; k++) begin
         step(1);
         if (ce != '0) cntx++;
      end
      check("inc_zero", longint'(cntx), 0);

      // Maximum increment
      cfg(2'd0, 1'b0, 32'hFFFF_FFFF);
      cfg(2'd0, 1'b1, 32'h0);
      pulse_sync();
      step(1);
      check("max_first_add", longint'(ce[0]), 0);
      cnt0 = 0;
      for (int k = 0; k < 64; k++) begin
         step(1);
         cnt0 += int'(ce[0]);
      end
      check("max_run", longint'(cnt0), 64);

      // Out-of-range channel writes change nothing
      cnt0 = 0;
      for (int k = 0; k < 20; k++) begin
         cfg(2'd3, 1'($urandom), $urandom);
         cnt0 += int'(ce[0]);
      end
      for (int k = 0; k < 50; k++) begin
         step(1);
         cnt0 += int'(ce[0]);
         cntx = int'(ce[2:1]);
      end
      check("bad_ch_ce0", longint'(cnt0), 70);
      check("bad_ch_others", longint'(cntx), 0);

      // Random traffic
      for (int k = 0; k < 3000; k++) begin
         cfg_wr = ($urandom % 4) == 0;
         cfg_ch = 2'($urandom);
         cfg_sel = 1'($urandom);
         cfg_data = ($urandom % 3 == 0) ? 32'hFFFF_FFFF - ($urandom % 16) : $urandom;
         sync = ($urandom % 16) == 0;
         if ($urandom % 300 == 0) pll_locked = 1'b0;
         else if ($urandom % 4 == 0) pll_locked = 1'b1;
         step(1);
      end
      cfg_wr = 1'b0;
      sync = 1'b0;
      pll_locked = 1'b0;
      step(4);

      // Reset mid-run
      pll_locked = 1'b1;
      wait_locked("pre_reset");
      cfg(2'd0, 1'b0, 32'hFFFF_FFFF);
      step(3);
      check("pre_reset_active", longint'(ce[0]), 1);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      check("rst_ce", longint'(ce), 0);
      check("rst_locked", longint'(locked), 0);
      wait_locked("post_reset");
      step(1);
      check("post_reset_inc_a", longint'(ce), 0);
      step(1);
      check("post_reset_inc_b", longint'(ce), 64'h7);
      step(2);

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/clken_gen.md
Name: clken_gen

Overview:
- Parametrised multi-channel fractional clock-enable generator, one clock domain.
- Sits behind the system PLL and derives NUM_CLOCKS independent, runtime-programmable enable strobes from the single PLL output clock, replacing fixed extra PLL outputs.
- Gates all strobes until the PLL lock has been stable for LOCK_CYCLES cycles.
- Supports per-channel phase offset and a global re-sync pulse.

Parameters:
- NUM_CLOCKS, 2, number of enable channels (1..8).
- ACC_W, 32, phase-accumulator width in bits (8..48).
- LOCK_CYCLES, 1024, cycles that synchronised pll_locked must stay high before strobes are released (>=1).
- INIT_INC, 0, increment loaded into every channel on reset (0 = channel silent).

Ports:
- refclk  in  1  sole clock (PLL output clock).
- rst  in  1  synchronous, active-high reset.
- pll_locked  in  1  PLL lock flag, asynchronous to refclk.
- sync  in  1  single-cycle pulse; reloads all accumulators from their phase registers.
- cfg_wr  in  1  configuration write strobe; accepted every cycle, no backpressure.
- cfg_ch  in  CH_W  target channel, where CH_W = max(1, clog2(NUM_CLOCKS)).
- cfg_sel  in  1  register select: 0 = increment, 1 = phase.
- cfg_data  in  ACC_W  write data.
- ce  out  NUM_CLOCKS  per-channel enable strobes, registered.
- locked  out  1  high while in RUN.

Behaviour:
- Input synchronisation: pll_locked passes through a 2-flop synchroniser, giving lk_s (2-cycle latency).
- Per-channel registers: inc[c] and phase[c], both ACC_W wide, plus accumulator acc[c].
- Reset (rst=1 on a clock edge):
  - inc[c]=INIT_INC, phase[c]=0, acc[c]=0.
  - ce=0, locked=0, settle counter=0, state=WAIT_LOCK.
  - Reset asserted mid-operation behaves identically; no strobe may appear in the cycle after rst.
- FSM states:
  - WAIT_LOCK:
    - acc[c] held at phase[c]; ce=0.
    - lk_s=1 -> SETTLE, counter cleared.
  - SETTLE:
    - Counter increments each cycle; acc held at phase[c]; ce=0.
    - lk_s=0 -> WAIT_LOCK.
    - Counter reaches LOCK_CYCLES-1 with lk_s=1 -> RUN.
  - RUN:
    - locked=1.
    - Each cycle, {carry, acc[c]} = acc[c] + inc[c], computed at ACC_W+1 bits, with modulo-2^ACC_W wrap of acc.
    - ce[c] is registered from carry, so it is high in the cycle after the carrying add.
    - lk_s=0 -> WAIT_LOCK in the next cycle. In that cycle locked=0, ce=0, and acc reloads from phase.
- Strobe rate: f(ce[c]) = f_refclk * inc[c] / 2^ACC_W.
  - inc=0: ce[c] never asserts.
  - ce is a one-cycle strobe; it is continuously high only if the carry fires every cycle.
- Config writes (cfg_wr=1):
  - cfg_sel=0 writes inc[cfg_ch]. The new value is used by the add starting the following cycle.
  - cfg_sel=1 writes phase[cfg_ch] only. It takes effect at the next sync or the next entry to RUN.
  - cfg_ch >= NUM_CLOCKS: write ignored, no state change.
- sync=1 in RUN:
  - All acc[c] load phase[c] simultaneously.
  - ce is 0 in the following cycle.
  - No add is performed in the sync cycle.
- sync outside RUN: no effect (acc is already held at phase).
- Simultaneous events:
  - sync + phase write to channel c in the same cycle: acc[c] loads cfg_data, and phase[c]=cfg_data.
  - sync + inc write in the same cycle: acc reloads; the new inc is used from the next cycle.
  - rst has priority over everything.
  - lk_s drop has priority over sync and the add.

Test Plan:
- Lock sequencing: NUM_CLOCKS=2, LOCK_CYCLES=16, INIT_INC=0x8000_0000; release rst, raise pll_locked at cycle 5.
  - Required: locked rises exactly 2+16 cycles later.
  - Required: ce[0] and ce[1] then toggle 0,1,0,1; ce stays 0 throughout WAIT_LOCK and SETTLE.
- Fractional rate: inc[0]=0x5555_5556, inc[1]=0x4000_0000, phase=0; count strobes over 300 RUN cycles.
  - Required: exactly 100 on ce[0] and 75 on ce[1].
- Phase and sync: phase[1]=0xC000_0000, inc[1]=0x4000_0000, then pulse sync.
  - Required: ce[1]=0 in the cycle after sync.
  - Required: ce[1]=1 in the next cycle, then every 4th cycle.
- Lock loss mid-run: drop pll_locked for 3 cycles while strobing.
  - Required: locked=0 and ce=0 within 3 cycles of the drop.
  - Required: after re-lock, strobes resume after the full LOCK_CYCLES settle, starting from phase values.
- Boundaries:
  - inc=0 -> no strobe in 1000 cycles.
  - inc=0xFFFF_FFFF -> ce high on 2^32-1 of every 2^32 cycles; check the first 64 cycles are high after the first add.
  - NUM_CLOCKS=3 with a write to cfg_ch=3 -> all registers unchanged.
- Reset mid-run: assert rst for 1 cycle while ce is active.
  - Required: ce=0 and locked=0 the next cycle.
  - Required: inc returns to INIT_INC; the FSM re-waits for lock.
